decoder_seq: RTL

DECODER_SEQ -- requirements
Module: decoder_seq

---
 rtl/decoder_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/decoder_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decoder_seq : registered one-hot decoder with direct-load and optional   |
// |               auto-scan mode (scan compiled in with DECODER_SEQ_SCAN_EN) |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module decoder_seq #(
   parameter int W    = 4,
   parameter int HOLD = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              E,
   input  logic [W-1:0]      a,
   input  logic              load,
   input  logic              scan,
   output logic [2**W-1:0]   D,
   output logic [W-1:0]      idx,
   output logic              busy,
   output logic              wrap
);
   localparam int N = 2**W;

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_DIRECT = 2'd1;

   logic [1:0]   r_state;
   logic [1:0]   w_state_nxt;
   logic [W-1:0] r_idx;
   logic [W-1:0] w_idx_nxt;
   logic [N-1:0] r_d;
   logic [N-1:0] w_d_nxt;

`ifdef DECODER_SEQ_SCAN_EN
   localparam logic [1:0]     c_SCAN      = 2'd2;
   localparam int             HCW         = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HCW-1:0] c_HOLD_LAST = HCW'(HOLD - 1);
   localparam logic [W-1:0]   c_IDX_LAST  = {W{1'b1}};

   logic [HCW-1:0] r_hold;
   logic [HCW-1:0] w_hold_nxt;
   logic           r_busy;
   logic           r_wrap;
   logic           w_scan_req;
   logic           w_step;

   // Load outranks scan, so a scan request only counts when no load is pending.
   assign w_scan_req = E && !load && scan;
   assign w_step     = (r_state == c_SCAN) && (r_hold == c_HOLD_LAST);

   always_comb begin
      w_hold_nxt = '0;
      if (w_scan_req && (r_state == c_SCAN) && !w_step)
         w_hold_nxt = r_hold + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold <= '0;
         r_busy <= 1'b0;
         r_wrap <= 1'b0;
      end else begin
         r_hold <= w_hold_nxt;
         r_busy <= (w_state_nxt == c_SCAN);
         r_wrap <= w_scan_req && w_step && (r_idx == c_IDX_LAST);
      end
   end

   assign busy = r_busy;
   assign wrap = r_wrap;
`else
   wire [8:0] w_unused_cfg = {scan, 8'(HOLD)};

   assign busy = 1'b0;
   assign wrap = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
         r_idx   <= '0;
         r_d     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_d     <= w_d_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!E)
         w_state_nxt = c_IDLE;
      else if (load)
         w_state_nxt = c_DIRECT;
`ifdef DECODER_SEQ_SCAN_EN
      else if (scan)
         w_state_nxt = c_SCAN;
      else if (r_state == c_SCAN)
         w_state_nxt = c_DIRECT;
`endif
   end

   // idx is retained through IDLE; only load or scan movement changes it.
   always_comb begin
      w_idx_nxt = r_idx;
      if (E && load)
         w_idx_nxt = a;
`ifdef DECODER_SEQ_SCAN_EN
      else if (w_scan_req) begin
         if (r_state != c_SCAN)
            w_idx_nxt = '0;
         else if (w_step)
            w_idx_nxt = r_idx + 1'b1;
      end
`endif
      w_d_nxt = '0;
      if (w_state_nxt != c_IDLE)
         w_d_nxt[w_idx_nxt] = 1'b1;
   end

   assign D   = r_d;
   assign idx = r_idx;

endmodule
`default_nettype wire
